// File: rtl/tc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tc_pkg: tile geometry, FSM encoding and packing offsets            |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package tc_pkg;

    localparam int TC_M   = 4;
    localparam int TC_K   = 8;
    localparam int TC_N   = 4;
    localparam int FP8_W  = 8;
    localparam int FP16_W = 16;
    localparam int TILE_W = 256;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    // Bit offsets of one element inside the flat A, B and C/D buses.
    function automatic int a_off(input int i, input int j);
        return (i * TC_K + j) * FP8_W;
    endfunction

    function automatic int b_off(input int j, input int k);
        return (j * TC_N + k) * FP8_W;
    endfunction

    function automatic int cd_off(input int i, input int k);
        return (i * TC_N + k) * FP16_W;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tc_tile_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tc_tile_sequencer_if: command, operand, core and result channels   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface tc_tile_sequencer_if #(
    parameter int CNT_W = 8
);
    logic                       cmd_valid;
    logic                       cmd_ready;
    logic [CNT_W-1:0]           cmd_chunks;
    logic                       cmd_e5m2;
    logic [tc_pkg::TILE_W-1:0]  cmd_c;

    logic                       op_valid;
    logic                       op_ready;
    logic [tc_pkg::TILE_W-1:0]  op_a;
    logic [tc_pkg::TILE_W-1:0]  op_b;

    logic                       tc_in_valid;
    logic                       tc_e5m2mode;
    logic [tc_pkg::TILE_W-1:0]  tc_a;
    logic [tc_pkg::TILE_W-1:0]  tc_b;
    logic [tc_pkg::TILE_W-1:0]  tc_c;
    logic                       tc_out_valid;
    logic [tc_pkg::TILE_W-1:0]  tc_d;

    logic                       res_valid;
    logic                       res_ready;
    logic [tc_pkg::TILE_W-1:0]  res_d;
    logic                       res_err;
    logic                       spurious;

    modport master (
        input  cmd_valid, cmd_chunks, cmd_e5m2, cmd_c,
        input  op_valid, op_a, op_b,
        input  tc_out_valid, tc_d,
        input  res_ready,
        output cmd_ready, op_ready,
        output tc_in_valid, tc_e5m2mode, tc_a, tc_b, tc_c,
        output res_valid, res_d, res_err, spurious
    );

    modport slave (
        output cmd_valid, cmd_chunks, cmd_e5m2, cmd_c,
        output op_valid, op_a, op_b,
        output tc_out_valid, tc_d,
        output res_ready,
        input  cmd_ready, op_ready,
        input  tc_in_valid, tc_e5m2mode, tc_a, tc_b, tc_c,
        input  res_valid, res_d, res_err, spurious
    );
endinterface
`default_nettype wire

// File: rtl/tc_tile_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tc_tile_sequencer: K-loop driver that chains tensorcore D into C   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tc_tile_sequencer
    import tc_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 64
) (
    input  wire logic            clk,
    input  wire logic            rst,
    tc_tile_sequencer_if.master  bus
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    state_t              r_state;
    state_t              w_next;
    logic [TILE_W-1:0]   r_acc;
    logic [TILE_W-1:0]   r_tc_a;
    logic [TILE_W-1:0]   r_tc_b;
    logic [TILE_W-1:0]   r_tc_c;
    logic [CNT_W-1:0]    r_rem;
    logic [TMR_W-1:0]    r_timer;
    logic                r_mode;
    logic                r_err;
    logic                r_spur;
    logic                w_timeout;

    assign w_timeout = (r_timer == TMR_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    w_next = (bus.cmd_chunks == '0) ? ST_RESP : ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (bus.op_valid) begin
                    w_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_next = ST_WAIT;
            end
            ST_WAIT: begin
                // A result landing on the timeout cycle still counts as done.
                if (bus.tc_out_valid) begin
                    w_next = (r_rem <= CNT_W'(1)) ? ST_RESP : ST_FETCH;
                end else if (w_timeout) begin
                    w_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.res_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc   <= '0;
            r_tc_a  <= '0;
            r_tc_b  <= '0;
            r_tc_c  <= '0;
            r_rem   <= '0;
            r_timer <= '0;
            r_mode  <= 1'b0;
            r_err   <= 1'b0;
            r_spur  <= 1'b0;
        end else begin
            if (bus.tc_out_valid && (r_state != ST_WAIT)) begin
                r_spur <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_acc  <= bus.cmd_c;
                        r_rem  <= bus.cmd_chunks;
                        r_mode <= bus.cmd_e5m2;
                        r_err  <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    if (bus.op_valid) begin
                        r_tc_a <= bus.op_a;
                        r_tc_b <= bus.op_b;
                        r_tc_c <= r_acc;
                    end
                end
                ST_ISSUE: begin
                    r_timer <= '0;
                end
                ST_WAIT: begin
                    if (bus.tc_out_valid) begin
                        r_acc <= bus.tc_d;
                        if (r_rem != '0) begin
                            r_rem <= r_rem - CNT_W'(1);
                        end
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                ST_RESP: begin
                    if (bus.res_ready) begin
                        r_err <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.cmd_ready   = (r_state == ST_IDLE);
    assign bus.op_ready    = (r_state == ST_FETCH);
    assign bus.tc_in_valid = (r_state == ST_ISSUE);
    assign bus.res_valid   = (r_state == ST_RESP);
    assign bus.res_d       = (r_state == ST_RESP) ? r_acc : '0;
    assign bus.res_err     = r_err;
    assign bus.tc_e5m2mode = r_mode;
    assign bus.tc_a        = r_tc_a;
    assign bus.tc_b        = r_tc_b;
    assign bus.tc_c        = r_tc_c;
    assign bus.spurious    = r_spur;

endmodule
`default_nettype wire

// File: tb/tb_tc_tile_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_tc_tile_sequencer: directed bench with a fixed-latency core stub |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_tc_tile_sequencer;
    import tc_pkg::*;

    logic clk;
    logic rst;

    tc_tile_sequencer_if #(.CNT_W(8)) bus ();

    tc_tile_sequencer #(
        .CNT_W   (8),
        .TIMEOUT (64)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic              stub_en;
    int                stub_lat;
    logic              stub_vld;
    logic [TILE_W-1:0] stub_d;
    logic              inj_vld;

    assign bus.tc_out_valid = stub_vld | inj_vld;
    assign bus.tc_d         = stub_d;

    int                issue_cnt = 0;
    int                oprdy_cnt = 0;
    logic [TILE_W-1:0] last_tc_c = '0;

    task automatic chk(input string tag, input logic [TILE_W-1:0] got, input logic [TILE_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [TILE_W-1:0] tile16(input logic [15:0] v);
        logic [TILE_W-1:0] r;
        r = '0;
        for (int i = 0; i < TC_M; i++)
            for (int k = 0; k < TC_N; k++)
                r[cd_off(i, k) +: 16] = v;
        return r;
    endfunction

    function automatic logic [TILE_W-1:0] tile8(input logic [7:0] v);
        logic [TILE_W-1:0] r;
        r = '0;
        for (int i = 0; i < TC_M; i++)
            for (int j = 0; j < TC_K; j++)
                r[a_off(i, j) +: 8] = v;
        return r;
    endfunction

    // Directed stub: A=B=1.0 gives D = C + 8.0 for the two C values used here.
    function automatic logic [TILE_W-1:0] stub_calc(input logic [TILE_W-1:0] a,
                                                     input logic [TILE_W-1:0] b,
                                                     input logic [TILE_W-1:0] c);
        logic [TILE_W-1:0] r;
        logic [15:0]       e;
        r = '0;
        for (int i = 0; i < TC_M; i++) begin
            for (int k = 0; k < TC_N; k++) begin
                e = c[cd_off(i, k) +: 16];
                if (a != tile8(8'h38) || b != tile8(8'h38)) r[cd_off(i, k) +: 16] = 16'hBAD0;
                else if (e == 16'h0000) r[cd_off(i, k) +: 16] = 16'h4800;
                else if (e == 16'h4800) r[cd_off(i, k) +: 16] = 16'h4C00;
                else                    r[cd_off(i, k) +: 16] = 16'hBAD1;
            end
        end
        return r;
    endfunction

    initial begin
        stub_vld = 1'b0;
        stub_d   = '0;
        forever begin
            @(negedge clk);
            if (stub_vld) begin
                stub_vld = 1'b0;
            end else if (bus.tc_in_valid && stub_en) begin
                stub_d = stub_calc(bus.tc_a, bus.tc_b, bus.tc_c);
                repeat (stub_lat - 1) @(negedge clk);
                stub_vld = 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        if (bus.tc_in_valid) begin
            issue_cnt++;
            last_tc_c = bus.tc_c;
        end
        if (bus.op_ready) oprdy_cnt++;
    end

    task automatic send_cmd(input string tag, input logic [7:0] chunks, input logic e5,
                            input logic [TILE_W-1:0] c);
        bus.cmd_valid  = 1'b1;
        bus.cmd_chunks = chunks;
        bus.cmd_e5m2   = e5;
        bus.cmd_c      = c;
        chk({tag, "_cmd_ready"}, bus.cmd_ready, 1'b1);
        @(negedge clk);
        bus.cmd_valid  = 1'b0;
    endtask

    task automatic wait_res(input string tag, input int max);
        int k;
        k = 0;
        while (!bus.res_valid && k < max) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_res_valid"}, bus.res_valid, 1'b1);
    endtask

    task automatic finish_res(input string tag);
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        chk({tag, "_idle_after"}, {bus.cmd_ready, bus.res_valid, bus.res_err}, 3'b100);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ctl"}, {bus.cmd_ready, bus.op_ready, bus.tc_in_valid, bus.res_valid,
                            bus.res_err, bus.spurious, bus.tc_e5m2mode}, 7'b1000000);
        chk({tag, "_buses"}, bus.tc_a | bus.tc_b | bus.tc_c | bus.res_d, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base_iss, base_op, d, bad;
        rst            = 1'b1;
        bus.cmd_valid  = 1'b0;
        bus.cmd_chunks = '0;
        bus.cmd_e5m2   = 1'b0;
        bus.cmd_c      = '0;
        bus.op_valid   = 1'b0;
        bus.op_a       = '0;
        bus.op_b       = '0;
        bus.res_ready  = 1'b0;
        stub_en        = 1'b1;
        stub_lat       = 3;
        inj_vld        = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("reset");

        // Single chunk
        bus.op_valid = 1'b1;
        bus.op_a     = tile8(8'h38);
        bus.op_b     = tile8(8'h38);
        base_iss     = issue_cnt;
        send_cmd("one", 8'd1, 1'b0, '0);
        wait_res("one", 50);
        chk("one_res_d", bus.res_d, tile16(16'h4800));
        chk("one_res_err", bus.res_err, 1'b0);
        chk("one_issues", issue_cnt - base_iss, 1);
        finish_res("one");

        // Two chunks: D of the first issue must be the C of the second
        base_iss = issue_cnt;
        send_cmd("two", 8'd2, 1'b0, '0);
        wait_res("two", 100);
        chk("two_issues", issue_cnt - base_iss, 2);
        chk("two_second_c", last_tc_c, tile16(16'h4800));
        chk("two_res_d", bus.res_d, tile16(16'h4C00));
        finish_res("two");

        // Zero chunks pass C straight through
        base_iss = issue_cnt;
        base_op  = oprdy_cnt;
        send_cmd("zero", 8'd0, 1'b1, tile16(16'h3C00));
        chk("zero_res_now", bus.res_valid, 1'b1);
        chk("zero_res_d", bus.res_d, tile16(16'h3C00));
        chk("zero_mode", bus.tc_e5m2mode, 1'b1);
        @(negedge clk);
        chk("zero_no_core", {issue_cnt - base_iss, oprdy_cnt - base_op}, 64'd0);
        finish_res("zero");

        // Timeout: 64 wait cycles after the issue cycle, then an error result
        stub_en = 1'b0;
        send_cmd("tmo", 8'd1, 1'b1, tile16(16'h1234));
        d = 0;
        while (!bus.tc_in_valid && d < 20) begin
            @(negedge clk);
            d++;
        end
        chk("tmo_issue", bus.tc_in_valid, 1'b1);
        d = 0;
        while (!bus.res_valid && d < 200) begin
            @(negedge clk);
            d++;
            if (d == 30) chk("tmo_wait_mode", bus.tc_e5m2mode, 1'b1);
        end
        chk("tmo_distance", d, 65);
        chk("tmo_res_err", bus.res_err, 1'b1);
        chk("tmo_res_d", bus.res_d, tile16(16'h1234));
        finish_res("tmo");

        // Result landing in the last wait cycle beats the timeout
        stub_en  = 1'b1;
        stub_lat = 65;
        send_cmd("edge", 8'd1, 1'b0, '0);
        wait_res("edge", 120);
        chk("edge_res_err", bus.res_err, 1'b0);
        chk("edge_res_d", bus.res_d, tile16(16'h4800));
        chk("edge_spurious", bus.spurious, 1'b0);
        finish_res("edge");
        stub_lat = 3;

        // Stalls on operand and result channels
        bus.op_valid = 1'b0;
        base_iss     = issue_cnt;
        send_cmd("stall", 8'd1, 1'b0, '0);
        bad = 0;
        repeat (10) begin
            if (!bus.op_ready || bus.tc_in_valid || bus.res_valid) bad++;
            @(negedge clk);
        end
        chk("stall_op", bad, 0);
        chk("stall_no_issue", issue_cnt - base_iss, 0);
        bus.op_valid = 1'b1;
        @(negedge clk);
        bus.op_valid = 1'b0;
        bus.op_a     = tile8(8'hFF);
        bus.op_b     = tile8(8'hFF);
        wait_res("stall", 50);
        bad = 0;
        repeat (5) begin
            if (!bus.res_valid || bus.res_d != tile16(16'h4800) || bus.tc_a != tile8(8'h38)) bad++;
            @(negedge clk);
        end
        chk("stall_res_hold", bad, 0);
        finish_res("stall");

        // Spurious strobe in IDLE
        inj_vld = 1'b1;
        @(negedge clk);
        inj_vld = 1'b0;
        chk("spur_idle", {bus.spurious, bus.cmd_ready}, 2'b11);

        // Reset while waiting on the core
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("spur_cleared", bus.spurious, 1'b0);
        stub_en      = 1'b0;
        bus.op_valid = 1'b1;
        bus.op_a     = tile8(8'h38);
        bus.op_b     = tile8(8'h38);
        send_cmd("rstw", 8'd3, 1'b1, tile16(16'h0400));
        @(negedge clk);
        @(negedge clk);
        chk("rstw_in_wait", {bus.op_ready, bus.tc_in_valid, bus.res_valid, bus.cmd_ready}, 4'b0000);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("rstw");
        bus.op_valid = 1'b0;
        inj_vld = 1'b1;
        @(negedge clk);
        inj_vld = 1'b0;
        chk("rstw_late_strobe", bus.spurious, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
